cart_loader: RTL and testbench

- Upstream write stage for the shared 64K system RAM.
- Takes the host ioctl byte stream for the cartridge index and buffers it in a one-entry holding register.
- Issues arbitrated writes into the cartridge window. It back-pressures the host with ioctl_wait while a write is pending.
- After download ends, pads the unused part of the window with a fill byte and raises cart_valid. cart_busy holds the CPU in reset for the whole operation.

---
 rtl/cart_loader_pkg.sv | 18 +
 rtl/cart_hold_reg.sv | 46 ++++
 rtl/cart_loader.sv | 176 +++++++++++++++++
 tb/tb_cart_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_loader_pkg.sv
// Shared definitions for the cartridge loader: FSM encoding, window defaults,
// fill byte and the host ioctl index constant.
package cart_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2
  } cart_state_t;

  localparam int                MEM_AW        = 16;
  localparam int                BYTE_W        = 8;
  localparam int                CART_AW_DEF   = 13;
  localparam logic [MEM_AW-1:0] CART_BASE_DEF = 16'h4000;
  localparam logic [BYTE_W-1:0] FILL_BYTE_DEF = 8'hFF;
  localparam logic [7:0]        IDX_CART      = 8'd1;

endpackage

// File: rtl/cart_hold_reg.sv
// One-entry write holding register: captures a byte and its RAM address and
// releases it when the arbiter grants the pending write.
module cart_hold_reg
  import cart_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cap,
  input  logic              gnt,
  input  logic [MEM_AW-1:0] cap_addr,
  input  logic [BYTE_W-1:0] cap_data,
  output logic              full,
  output logic              ready,
  output logic              drain,
  output logic [MEM_AW-1:0] addr,
  output logic [BYTE_W-1:0] data
);

  logic              full_q, full_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] data_q, data_d;

  // A grant in the same cycle frees the slot, so capture may overlap drain.
  always_comb begin
    drain  = full_q & gnt;
    ready  = ~full_q | gnt;
    full_d = (full_q & ~gnt) | cap;
    addr_d = cap ? cap_addr : addr_q;
    data_d = cap ? cap_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/cart_loader.sv
// Cartridge download writer: buffers host ioctl bytes into the RAM window and
// pads the rest with a fill byte. CART_CHECKSUM_EN adds a running byte checksum.
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter logic [7:0]  INDEX     = IDX_CART,
  parameter logic [15:0] CART_BASE = CART_BASE_DEF,
  parameter int          AW        = CART_AW_DEF,
  parameter logic [7:0]  FILL_BYTE = FILL_BYTE_DEF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_we,
  output logic [15:0]   mem_addr,
  output logic [7:0]    mem_din,
  input  logic          mem_gnt,
  output logic          cart_busy,
  output logic          cart_valid,
  output logic [AW:0]   cart_size,
  output logic          cart_ovf,
  output logic [7:0]    cart_sum
);

  localparam logic [AW:0] WIN  = (AW+1)'(1) << AW;
  localparam logic [AW:0] LAST = WIN - (AW+1)'(1);

  cart_state_t state_q, state_d;
  logic [AW:0] ptr_q, ptr_d, size_q, size_d, size_cand;
  logic        valid_q, valid_d, ovf_q, ovf_d, busy_q, busy_d, dl_q;
  logic        start, load_start, addr_oor;
  logic        hold_cap, hold_ready, hold_full, hold_drain;
  logic [15:0] hold_addr, cap_addr;
  logic [7:0]  hold_data;

  assign start      = ioctl_download & ~dl_q & (ioctl_index == INDEX);
  assign load_start = start & (state_q != ST_LOAD);
  assign addr_oor   = |ioctl_addr[24:AW];
  assign size_cand  = {1'b0, ioctl_addr[AW-1:0]} + (AW+1)'(1);
  assign cap_addr   = CART_BASE + 16'(ioctl_addr[AW-1:0]);

  cart_hold_reg u_hold (
    .clk      (clk_sys),
    .rst      (reset),
    .cap      (hold_cap),
    .gnt      (mem_gnt),
    .cap_addr (cap_addr),
    .cap_data (ioctl_dout),
    .full     (hold_full),
    .ready    (hold_ready),
    .drain    (hold_drain),
    .addr     (hold_addr),
    .data     (hold_data)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    size_d   = size_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    hold_cap = 1'b0;
    // A fresh start also aborts an in-progress fill.
    if (load_start) begin
      state_d = ST_LOAD;
      size_d  = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (ioctl_wr) begin
            if (addr_oor) begin
              ovf_d  = 1'b1;
              size_d = WIN;
            end else if (hold_ready) begin
              hold_cap = 1'b1;
              if (size_cand > size_q) size_d = size_cand;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (!ioctl_download && !hold_full) begin
            if (size_q == '0) begin
              state_d = ST_IDLE;
            end else if (size_q == WIN) begin
              state_d = ST_IDLE;
              valid_d = 1'b1;
            end else begin
              state_d = ST_FILL;
              ptr_d   = size_q;
            end
          end
        end
        ST_FILL: begin
          if (mem_gnt) begin
            if (ptr_q == LAST) begin
              state_d = ST_IDLE;
              valid_d = 1'b1;
            end else begin
              ptr_d = ptr_q + (AW+1)'(1);
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      size_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      size_q  <= size_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      dl_q    <= ioctl_download;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (state_q == ST_FILL) begin
      mem_we   = 1'b1;
      mem_addr = CART_BASE + 16'(ptr_q[AW-1:0]);
      mem_din  = FILL_BYTE;
    end else if (hold_full) begin
      mem_we   = 1'b1;
      mem_addr = hold_addr;
      mem_din  = hold_data;
    end
  end

`ifdef CART_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  // Only image bytes that actually reach RAM contribute.
  always_comb begin
    sum_d = sum_q;
    if (load_start)                           sum_d = '0;
    else if (state_q == ST_LOAD && hold_drain) sum_d = sum_q + hold_data;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign cart_sum = sum_q;
`else
  assign cart_sum = 8'h00;
`endif

  assign ioctl_wait = hold_full;
  assign cart_busy  = busy_q;
  assign cart_valid = valid_q;
  assign cart_size  = size_q;
  assign cart_ovf   = ovf_q;

endmodule

// File: tb/tb_cart_loader.sv
// Scoreboard bench for cart_loader: expected RAM writes are queued as stimulus
// is driven and checked as the DUT issues granted writes.
module tb_cart_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_gnt = 1'b0;
  logic        cart_busy, cart_valid, cart_ovf;
  logic [13:0] cart_size;
  logic [7:0]  cart_sum;

  int          nvec = 0;
  int          nerr = 0;
  int          wr_cnt = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  exp_sum = '0;

  cart_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_gnt        (mem_gnt),
    .cart_busy      (cart_busy),
    .cart_valid     (cart_valid),
    .cart_size      (cart_size),
    .cart_ovf       (cart_ovf),
    .cart_sum       (cart_sum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Granted writes are checked against the scoreboard between clock edges.
  always @(negedge clk_sys) begin
    if (reset === 1'b0 && mem_we === 1'b1 && mem_gnt === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("unexp_wr", {8'h0, mem_addr, mem_din}, 32'hFFFF_FFFF);
      else chk("wr", {8'h0, mem_addr, mem_din}, {8'h0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == 8'd1) exp_sum = '0;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic send_byte(input int off, input logic [7:0] d, input bit push);
    int n = 0;
    while (ioctl_wait === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_tmo", {31'b0, ioctl_wait}, 32'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(off);
    ioctl_dout = d;
    if (push && off < 8192) begin
      exp_q.push_back({16'h4000 + 16'(off), d});
      exp_sum += d;
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic push_fill(input int from);
    for (int a = from; a < 8192; a++) exp_q.push_back({16'h4000 + 16'(a), 8'hFF});
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (cart_busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, cart_busy}, 32'd0);
  endtask

  task automatic chk_sum(input string tag);
`ifdef CART_CHECKSUM_EN
    chk(tag, {24'b0, cart_sum}, {24'b0, exp_sum});
`else
    chk(tag, {24'b0, cart_sum}, 32'd0);
`endif
  endtask

  initial begin
    logic [13:0] s_size;
    logic        s_valid, s_ovf;
    logic [7:0]  s_sum;
    int          n;

    tick();
    tick();
    chk("rst_we",    {31'b0, mem_we},     32'd0);
    chk("rst_wait",  {31'b0, ioctl_wait}, 32'd0);
    chk("rst_busy",  {31'b0, cart_busy},  32'd0);
    chk("rst_valid", {31'b0, cart_valid}, 32'd0);
    chk("rst_size",  {18'b0, cart_size},  32'd0);
    chk("rst_ovf",   {31'b0, cart_ovf},   32'd0);
    chk("rst_sum",   {24'b0, cart_sum},   32'd0);
    reset = 1'b0;
    tick();

    // Stall-free 4-byte image followed by a full fill.
    mem_gnt = 1'b1;
    wr_cnt  = 0;
    start_dl(8'd1);
    chk("t1_busy", {31'b0, cart_busy}, 32'd1);
    for (int i = 0; i < 4; i++) send_byte(i, 8'hA0 + 8'(i), 1'b1);
    push_fill(4);
    end_dl();
    wait_idle(20000, "t1_idle");
    chk("t1_wrcnt", wr_cnt, 32'd8192);
    chk("t1_valid", {31'b0, cart_valid}, 32'd1);
    chk("t1_size",  {18'b0, cart_size},  32'd4);
    chk("t1_ovf",   {31'b0, cart_ovf},   32'd0);
    chk("t1_qempty", exp_q.size(), 32'd0);
    chk_sum("t1_sum");

    // Grant withheld: wait must hold, then an illegal strobe is dropped.
    mem_gnt = 1'b0;
    start_dl(8'd1);
    chk("t2_valid_clr", {31'b0, cart_valid}, 32'd0);
    send_byte(0, 8'hB5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_wait", {31'b0, ioctl_wait}, 32'd1);
      tick();
    end
    chk("t2_ovf0", {31'b0, cart_ovf}, 32'd0);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd1;
    ioctl_dout = 8'hC6;
    tick();
    ioctl_wr = 1'b0;
    chk("t2_drop_ovf", {31'b0, cart_ovf}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    chk("t2_wait_clr", {31'b0, ioctl_wait}, 32'd0);
    push_fill(1);
    end_dl();
    wait_idle(20000, "t2_idle");
    chk("t2_valid", {31'b0, cart_valid}, 32'd1);
    chk("t2_size",  {18'b0, cart_size},  32'd1);
    chk("t2_ovf",   {31'b0, cart_ovf},   32'd1);
    chk("t2_qempty", exp_q.size(), 32'd0);
    chk_sum("t2_sum");

    // Oversize image: tail discarded, no fill phase.
    wr_cnt = 0;
    start_dl(8'd1);
    for (int i = 0; i < 8200; i++) send_byte(i, 8'(i) ^ 8'h5A, 1'b1);
    end_dl();
    wait_idle(50, "t3_idle");
    chk("t3_wrcnt", wr_cnt, 32'd8192);
    chk("t3_valid", {31'b0, cart_valid}, 32'd1);
    chk("t3_size",  {18'b0, cart_size},  32'd8192);
    chk("t3_ovf",   {31'b0, cart_ovf},   32'd1);
    chk("t3_qempty", exp_q.size(), 32'd0);
    chk_sum("t3_sum");

    // Foreign index must leave everything alone.
    s_size  = cart_size;
    s_valid = cart_valid;
    s_ovf   = cart_ovf;
    s_sum   = cart_sum;
    wr_cnt  = 0;
    start_dl(8'd2);
    chk("t5_busy", {31'b0, cart_busy}, 32'd0);
    for (int i = 0; i < 3; i++) send_byte(i, 8'h11 * 8'(i + 1), 1'b0);
    end_dl();
    tick();
    chk("t5_wrcnt", wr_cnt, 32'd0);
    chk("t5_size",  {18'b0, cart_size},  {18'b0, s_size});
    chk("t5_valid", {31'b0, cart_valid}, {31'b0, s_valid});
    chk("t5_ovf",   {31'b0, cart_ovf},   {31'b0, s_ovf});
    chk("t5_sum",   {24'b0, cart_sum},   {24'b0, s_sum});

    // Async reset in the middle of the fill, then a clean reload.
    start_dl(8'd1);
    send_byte(0, 8'h77, 1'b1);
    push_fill(1);
    end_dl();
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr === 16'h4064) && n < 500) begin
      tick();
      n++;
    end
    chk("t6_reach", {16'b0, mem_addr}, 32'h4064);
    reset = 1'b1;
    #1;
    chk("t6_we",    {31'b0, mem_we},     32'd0);
    chk("t6_addr",  {16'b0, mem_addr},   32'd0);
    chk("t6_din",   {24'b0, mem_din},    32'd0);
    chk("t6_busy",  {31'b0, cart_busy},  32'd0);
    chk("t6_valid", {31'b0, cart_valid}, 32'd0);
    chk("t6_size",  {18'b0, cart_size},  32'd0);
    chk("t6_ovf",   {31'b0, cart_ovf},   32'd0);
    chk("t6_sum",   {24'b0, cart_sum},   32'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    start_dl(8'd1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(1, 8'hFF, 1'b1);
    send_byte(2, 8'h10, 1'b1);
    push_fill(3);
    end_dl();
    wait_idle(20000, "t7_idle");
    chk("t7_valid", {31'b0, cart_valid}, 32'd1);
    chk("t7_size",  {18'b0, cart_size},  32'd3);
    chk("t7_ovf",   {31'b0, cart_ovf},   32'd0);
    chk("t7_qempty", exp_q.size(), 32'd0);
`ifdef CART_CHECKSUM_EN
    chk("t7_sum", {24'b0, cart_sum}, 32'h10);
`else
    chk("t7_sum", {24'b0, cart_sum}, 32'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
